// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single program/data memory between the processor
// core and a host loader/debug port. The core owns the bus by default; a host
// access is only granted at an instruction boundary (phase 7) or while the core
// is halted, and the core's phase counter is frozen for the whole host access.
module mem_arbiter #(
  parameter int AW             = 5,
  parameter int DW             = 8,
  parameter int MAX_HOST_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  // core side
  input  logic [2:0]    cpu_phase,
  input  logic          cpu_halted,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  // host side
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_done,
  output logic [DW-1:0] host_rdata,
  // memory side
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    CPU    = 3'd0,
    H_ADDR = 3'd1,
    H_XFER = 3'd2,
    H_ACK  = 3'd3,
    H_ARB  = 3'd4
  } state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_HOST_BURST);
  localparam logic [3:0] BURST_SAT   = 4'd15;

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    burst_cnt;

  // State register; reset parks the bus with the core, aborting any host access.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) state <= CPU;
    else     state <= next_state;
  end

  // Next-state logic: host_req is only looked at in CPU and H_ARB.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves next_state
    // unassigned, which would otherwise infer a latch.
    next_state = state;
    unique case (state)
      CPU:     if (host_req && (cpu_halted || cpu_phase == 3'd7)) next_state = H_ADDR;
      H_ADDR:  next_state = H_XFER;
      H_XFER:  next_state = H_ACK;
      H_ACK:   next_state = H_ARB;
      H_ARB:   if (host_req && (cpu_halted || burst_cnt < BURST_LIMIT)) next_state = H_ADDR;
               else                                                       next_state = CPU;
      default: next_state = CPU;
    endcase
  end

  // Request holding registers, burst counter and host read-data capture.
  always_ff @(posedge clk) begin
    // NOTE: these are a handful of flops, not a memory array, so all of them
    // get a reset value; the shared memory itself lives outside this block.
    if (rst) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      burst_cnt  <= '0;
      host_rdata <= '0;
    end else begin
      if (next_state == H_ADDR) begin
        // Entering H_ADDR: latch the request so the host may change it freely.
        addr_q  <= host_addr;
        we_q    <= host_we;
        wdata_q <= host_wdata;
        if (state == CPU)                burst_cnt <= 4'd1;
        else if (burst_cnt != BURST_SAT) burst_cnt <= burst_cnt + 4'd1;
      end else if (state == H_ARB) begin
        // Burst over: the core gets the bus back and the count restarts.
        burst_cnt <= '0;
      end
      if (state == H_XFER && !we_q) host_rdata <= mem_rdata;
    end
  end

  // Output decode: core passthrough in CPU, latched host request otherwise.
  always_comb begin
    cpu_stall = (state != CPU);
    host_gnt  = (state == H_ADDR) || (state == H_XFER);
    host_done = (state == H_ACK);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    unique case (state)
      CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
      end
      H_ADDR:  mem_rd = ~we_q;
      H_XFER: begin
        mem_rd = ~we_q;
        mem_wr = we_q;
      end
      default: ;
    endcase
  end

  // The core reads memory directly; only meaningful while in CPU.
  assign cpu_rdata = mem_rdata;

endmodule
